inc_counter: RTL and testbench



---
 rtl/inc_counter.sv | 131 +++++++++++++
 tb/tb_inc_counter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/inc_counter.sv
// inc_counter: loadable up-counter that runs from a start value to a
// programmed terminal value. It reports progress with busy, a one-cycle
// done pulse and a one-cycle wrap pulse on all-ones -> 0 rollover.
//
// Build option: define INC_COUNTER_SAT_EN to make the counter saturate.
// An all-ones count then ends the run, the count never rolls over, and
// wrap stays low.
module inc_counter #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] base,
  input  logic [DATAWIDTH-1:0] limit,
  input  logic                 stall,
  output logic [DATAWIDTH-1:0] q,
  output logic                 busy,
  output logic                 done,
  output logic                 wrap
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [DATAWIDTH-1:0] ALL_ONES = {DATAWIDTH{1'b1}};
  localparam logic [DATAWIDTH-1:0] ONE      = DATAWIDTH'(1);

  state_t                 state_r;
  logic [DATAWIDTH-1:0]   q_r;
  logic [DATAWIDTH-1:0]   limit_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   wrap_r;

  logic [DATAWIDTH-1:0]   q_inc_s;
  logic                   match_s;
  logic                   at_max_s;

  // Next count and terminal-condition decode from the registered count.
  always_comb begin
    q_inc_s  = q_r + ONE;
    match_s  = (q_r == limit_r);
    at_max_s = (q_r == ALL_ONES);
  end

  // Control FSM together with the count, latched limit and output flags.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= ST_IDLE;
      q_r     <= '0;
      limit_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          wrap_r <= 1'b0;
          if (start) begin
            q_r     <= base;
            limit_r <= limit;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end

        ST_RUN: begin
          if (match_s) begin
            // The limit match ends the run even when stalled.
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            wrap_r  <= 1'b0;
            state_r <= ST_DONE;
`ifdef INC_COUNTER_SAT_EN
          end else if (at_max_s) begin
            // Saturation: all-ones is terminal, so the count never rolls over.
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            wrap_r  <= 1'b0;
            state_r <= ST_DONE;
`endif
          end else if (!stall) begin
            q_r     <= q_inc_s;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
`ifdef INC_COUNTER_SAT_EN
            wrap_r  <= 1'b0;
`else
            wrap_r  <= at_max_s;
`endif
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            wrap_r  <= 1'b0;
            state_r <= ST_RUN;
          end
        end

        ST_DONE: begin
          // One-cycle completion state; start requests here are dropped.
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          wrap_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          wrap_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign q    = q_r;
  assign busy = busy_r;
  assign done = done_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_inc_counter.sv
// Directed testbench for inc_counter at DATAWIDTH=8. A vector table covers
// the basic, equal-bounds, wrap and max-limit runs; hand-written sequences
// cover stall, reset abort and ignored start requests.
module tb_inc_counter;

  logic       Clk;
  logic       Rst;
  logic       start;
  logic [7:0] base;
  logic [7:0] limit;
  logic       stall;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       wrap;

  int n_checks;
  int n_fail;

  typedef struct {
    logic       rst;
    logic       start;
    logic [7:0] base;
    logic [7:0] limit;
    logic       stall;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];

  inc_counter #(.DATAWIDTH(8)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (start),
    .base  (base),
    .limit (limit),
    .stall (stall),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic vec_t mk(input logic r, input logic s, input logic [7:0] b,
                              input logic [7:0] l, input logic st, input logic [7:0] eq,
                              input logic eb, input logic ed, input logic ew);
    vec_t v;
    v.rst = r; v.start = s; v.base = b; v.limit = l; v.stall = st;
    v.q = eq; v.busy = eb; v.done = ed; v.wrap = ew;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Apply inputs, take one rising edge, and settle 1 time unit after it.
  task automatic drive(input logic r, input logic s, input logic [7:0] b,
                       input logic [7:0] l, input logic st);
    Rst = r; start = s; base = b; limit = l; stall = st;
    @(posedge Clk);
    #1;
  endtask

  task automatic expect4(input string tag, input logic [7:0] eq, input logic eb,
                         input logic ed, input logic ew);
    chk({tag, " q"}, q, eq);
    chk({tag, " busy"}, {7'd0, busy}, {7'd0, eb});
    chk({tag, " done"}, {7'd0, done}, {7'd0, ed});
    chk({tag, " wrap"}, {7'd0, wrap}, {7'd0, ew});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Rst = 1'b1; start = 1'b0; base = 8'h00; limit = 8'h00; stall = 1'b0;

    // Reset state
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 8'h55, 8'h66, 1'b0);
    expect4("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    expect4("idle after reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // Basic run 05 -> 08
    vecs.push_back(mk(1'b0, 1'b1, 8'h05, 8'h08, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h05, 8'h08, 1'b0, 8'h06, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h05, 8'h08, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h05, 8'h08, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h05, 8'h08, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h05, 8'h08, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h33, 8'h44, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0));
    // Equal bounds 10 -> 10
    vecs.push_back(mk(1'b0, 1'b1, 8'h10, 8'h10, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h10, 8'h10, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h10, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'h10, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0));
    // Wrap run FE -> 01
    vecs.push_back(mk(1'b0, 1'b1, 8'hFE, 8'h01, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'hFE, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0));
`ifdef INC_COUNTER_SAT_EN
    vecs.push_back(mk(1'b0, 1'b0, 8'hFE, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'hFE, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'hFE, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0));
`else
    vecs.push_back(mk(1'b0, 1'b0, 8'hFE, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'hFE, 8'h01, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'hFE, 8'h01, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'hFE, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0));
`endif
    // Limit at all-ones: FD -> FF, same result in both builds
    vecs.push_back(mk(1'b0, 1'b1, 8'hFD, 8'hFF, 1'b0, 8'hFD, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'hFD, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'hFD, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'hFD, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 8'hFD, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].base, vecs[i].limit, vecs[i].stall);
      expect4($sformatf("vec%0d", i), vecs[i].q, vecs[i].busy, vecs[i].done, vecs[i].wrap);
    end

    // Stall: 00 -> 04, three stalled cycles at q=2, stall at q=4 ignored
    drive(1'b0, 1'b1, 8'h00, 8'h04, 1'b0); expect4("stall e0", 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 8'h04, 1'b0); expect4("stall e1", 8'h01, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 8'h04, 1'b0); expect4("stall e2", 8'h02, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 8'h00, 8'h04, 1'b1);
      expect4($sformatf("stall hold%0d", k), 8'h02, 1'b1, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 8'h00, 8'h04, 1'b0); expect4("stall e6", 8'h03, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 8'h04, 1'b0); expect4("stall e7", 8'h04, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 8'h04, 1'b1); expect4("stall e8 done", 8'h04, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 8'h04, 1'b0); expect4("stall e9 idle", 8'h04, 1'b0, 1'b0, 1'b0);

    // Reset abort in a 05 -> 09 run once q=6 is visible
    drive(1'b0, 1'b1, 8'h05, 8'h09, 1'b0); expect4("abort e0", 8'h05, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h05, 8'h09, 1'b0); expect4("abort e1", 8'h06, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h05, 8'h09, 1'b0); expect4("abort reset", 8'h00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 8'h05, 8'h09, 1'b0);
      expect4($sformatf("abort quiet%0d", k), 8'h00, 1'b0, 1'b0, 1'b0);
    end

    // Start requests with new base/limit during RUN and DONE are ignored
    drive(1'b0, 1'b1, 8'h05, 8'h09, 1'b0); expect4("ign e0", 8'h05, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h05, 8'h09, 1'b0); expect4("ign e1", 8'h06, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h20, 8'h21, 1'b0); expect4("ign e2", 8'h07, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h20, 8'h21, 1'b0); expect4("ign e3", 8'h08, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h20, 8'h21, 1'b0); expect4("ign e4", 8'h09, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h20, 8'h21, 1'b0); expect4("ign e5 done", 8'h09, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 8'h20, 8'h21, 1'b0); expect4("ign e6 in done", 8'h09, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h20, 8'h21, 1'b0); expect4("ign e7 idle", 8'h09, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
